// File: rtl/occupancy_bcd_sequencer_if.sv
// Event/count bundle between the sensor decoder, the occupancy sequencer and the display driver.
// Latency: none (wires only).
// Backpressure: none; event pulses are fire-and-forget, status outputs are level signals.
interface occupancy_bcd_sequencer_if;
  logic        enter_req;
  logic        exit_req;
  logic [15:0] count_bcd;
  logic        full;
  logic        empty;
  logic        busy;
  logic        rejected;
  logic        lost;

  // Event source side (sensor FSM / bench)
  modport master (
    output enter_req,
    output exit_req,
    input  count_bcd,
    input  full,
    input  empty,
    input  busy,
    input  rejected,
    input  lost
  );

  // Sequencer side
  modport slave (
    input  enter_req,
    input  exit_req,
    output count_bcd,
    output full,
    output empty,
    output busy,
    output rejected,
    output lost
  );
endinterface

// File: rtl/occupancy_bcd_sequencer.sv
// Owns the 4-digit BCD occupancy count; enter/exit pulses become one-digit-per-clock BCD steps.
// Latency: request at edge N, IDLE decision at N+1, commit at N+1+k (k = digits touched, 1..4).
// Backpressure: none; one pending event per direction is held, a further request pulses lost.
module occupancy_bcd_sequencer #(
  // Lot capacity as 4-digit BCD: every nibble 0..9, nonzero, at most 16'h9999
  parameter logic [15:0] MAX_BCD = 16'h0500
) (
  input  logic                            clk,
  input  logic                            rst,
  occupancy_bcd_sequencer_if.slave        bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_STEP = 1'b1
  } state_t;

  typedef enum logic {
    OP_INC = 1'b0,
    OP_DEC = 1'b1
  } op_t;

  // Architectural state
  state_t      r_state;
  logic        r_pend_in;
  logic        r_pend_out;
  logic [15:0] r_work;
  logic [1:0]  r_idx;
  op_t         r_op;
  logic [15:0] r_count;
  logic        r_rejected;
  logic        r_lost;

  // Next-state / decode wires
  state_t      w_state_nxt;
  logic [15:0] w_work_nxt;
  logic [1:0]  w_idx_nxt;
  op_t         w_op_nxt;
  logic [15:0] w_count_nxt;
  logic        w_rejected_nxt;
  logic        w_clr_in;
  logic        w_clr_out;
  logic        w_pend_in_nxt;
  logic        w_pend_out_nxt;
  logic        w_lost_nxt;

  logic        w_full;
  logic        w_empty;
  logic [3:0]  w_shamt;
  logic [3:0]  w_digit;
  logic        w_wrap;
  logic [3:0]  w_new_digit;
  logic [15:0] w_work_upd;

  // Status is decoded straight from the committed count, so it tracks count_bcd with no lag
  assign w_full  = (r_count == MAX_BCD);
  assign w_empty = (r_count == 16'h0000);

  // Digit under the pointer; bit offset is idx*4
  assign w_shamt = {r_idx, 2'b00};
  assign w_digit = 4'(r_work >> w_shamt);

  // A digit wraps when INC sees 9 or DEC sees 0; that is the only case that ripples on
  assign w_wrap = (r_op == OP_INC) ? (w_digit == 4'd9) : (w_digit == 4'd0);

  // Replacement value for the digit under the pointer
  always_comb begin
    w_new_digit = w_digit;
    if (r_op == OP_INC) begin
      w_new_digit = w_wrap ? 4'd0 : (w_digit + 4'd1);
    end else begin
      w_new_digit = w_wrap ? 4'd9 : (w_digit - 4'd1);
    end
  end

  // Scratch word with only the pointed-to digit replaced
  assign w_work_upd = (r_work & ~(16'h000F << w_shamt)) |
                      ({12'h000, w_new_digit} << w_shamt);

  // FSM next-state: IDLE arbitrates pending flags, STEP ripples one digit per clock
  always_comb begin
    w_state_nxt    = r_state;
    w_work_nxt     = r_work;
    w_idx_nxt      = r_idx;
    w_op_nxt       = r_op;
    w_count_nxt    = r_count;
    w_rejected_nxt = 1'b0;
    w_clr_in       = 1'b0;
    w_clr_out      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_pend_in && r_pend_out) begin
          // Opposite events cancel: net change is zero, nothing to report
          w_clr_in  = 1'b1;
          w_clr_out = 1'b1;
        end else if (r_pend_in) begin
          w_clr_in = 1'b1;
          if (w_full) begin
            w_rejected_nxt = 1'b1;
          end else begin
            w_work_nxt  = r_count;
            w_op_nxt    = OP_INC;
            w_idx_nxt   = 2'd0;
            w_state_nxt = S_STEP;
          end
        end else if (r_pend_out) begin
          w_clr_out = 1'b1;
          if (w_empty) begin
            w_rejected_nxt = 1'b1;
          end else begin
            w_work_nxt  = r_count;
            w_op_nxt    = OP_DEC;
            w_idx_nxt   = 2'd0;
            w_state_nxt = S_STEP;
          end
        end
      end

      S_STEP: begin
        w_work_nxt = w_work_upd;
        // The full/empty guards mean digit 3 never wraps; treating idx==3 as terminal
        // keeps the pointer from ever running past the top digit.
        if (w_wrap && (r_idx != 2'd3)) begin
          w_idx_nxt = r_idx + 2'd1;
        end else begin
          w_count_nxt = w_work_upd;
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture wins over a same-cycle clear; a request into an already-held flag is dropped
  always_comb begin
    w_pend_in_nxt  = bus.enter_req | (r_pend_in  & ~w_clr_in);
    w_pend_out_nxt = bus.exit_req  | (r_pend_out & ~w_clr_out);
    w_lost_nxt     = (bus.enter_req & r_pend_in  & ~w_clr_in) |
                     (bus.exit_req  & r_pend_out & ~w_clr_out);
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath registers: scratch word, digit pointer, operation, committed count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work  <= 16'h0000;
      r_idx   <= 2'd0;
      r_op    <= OP_INC;
      r_count <= 16'h0000;
    end else begin
      r_work  <= w_work_nxt;
      r_idx   <= w_idx_nxt;
      r_op    <= w_op_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Pending flags and the one-cycle status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_in  <= 1'b0;
      r_pend_out <= 1'b0;
      r_rejected <= 1'b0;
      r_lost     <= 1'b0;
    end else begin
      r_pend_in  <= w_pend_in_nxt;
      r_pend_out <= w_pend_out_nxt;
      r_rejected <= w_rejected_nxt;
      r_lost     <= w_lost_nxt;
    end
  end

  assign bus.count_bcd = r_count;
  assign bus.full      = w_full;
  assign bus.empty     = w_empty;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.rejected  = r_rejected;
  assign bus.lost      = r_lost;

endmodule

// File: tb/tb_occupancy_bcd_sequencer.sv
// Directed and soak bench for the occupancy sequencer, two instances with different capacities.
// Latency: checks are taken 1 time unit after each rising edge.
// Backpressure: none; the bench waits for busy to drop where it needs a settled count.
module tb_occupancy_bcd_sequencer;

  localparam logic [15:0] MAX_A = 16'h9999;
  localparam logic [15:0] MAX_B = 16'h0003;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int rej_a    = 0;
  int rej_b    = 0;
  int lost_a   = 0;
  int lost_b   = 0;

  occupancy_bcd_sequencer_if bus_a ();
  occupancy_bcd_sequencer_if bus_b ();

  occupancy_bcd_sequencer #(.MAX_BCD(MAX_A)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  occupancy_bcd_sequencer #(.MAX_BCD(MAX_B)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  always #5 clk = ~clk;

  // Pulse counters (each pulse is high for exactly one cycle, so one sample per edge counts it once)
  always @(posedge clk) begin
    if (bus_a.rejected) rej_a  <= rej_a + 1;
    if (bus_b.rejected) rej_b  <= rej_b + 1;
    if (bus_a.lost)     lost_a <= lost_a + 1;
    if (bus_b.lost)     lost_b <= lost_b + 1;
  end

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic bcd_ok(input logic [15:0] v, input logic [15:0] mx);
    return (v[15:12] <= 4'd9) && (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) &&
           (v[3:0] <= 4'd9) && (v <= mx);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ea, input logic xa, input logic eb, input logic xb);
    bus_a.enter_req = ea;
    bus_a.exit_req  = xa;
    bus_b.enter_req = eb;
    bus_b.exit_req  = xb;
  endtask

  // One-cycle pulse; returns just after the capture edge N
  task automatic pulse(input logic ea, input logic xa, input logic eb, input logic xb);
    drive(ea, xa, eb, xb);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Let the IDLE edge happen, then wait (bounded) until both instances are idle
  task automatic wait_idle();
    int c = 0;
    tick();
    while ((bus_a.busy || bus_b.busy) && c < 20) begin
      tick();
      c++;
    end
    n_checks++;
    if (bus_a.busy || bus_b.busy) begin
      n_fail++;
      $display("FAIL idle_timeout busy_a=%b busy_b=%b required 0 0", bus_a.busy, bus_b.busy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic preload_a(input int n);
    for (int i = 0; i < n; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      wait_idle();
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus_a.count_bcd !== 16'h0000 || bus_b.count_bcd !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_count got %h/%h required 0000/0000", bus_a.count_bcd, bus_b.count_bcd);
    end
    n_checks++;
    if ({bus_a.empty, bus_a.full, bus_a.busy, bus_a.rejected, bus_a.lost} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags_a got %b required 10000",
               {bus_a.empty, bus_a.full, bus_a.busy, bus_a.rejected, bus_a.lost});
    end
    n_checks++;
    if ({bus_b.empty, bus_b.full, bus_b.busy, bus_b.rejected, bus_b.lost} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags_b got %b required 10000",
               {bus_b.empty, bus_b.full, bus_b.busy, bus_b.rejected, bus_b.lost});
    end
  endtask

  task automatic test_carry();
    logic [15:0] exp_c;
    logic        exp_b;
    do_reset();
    preload_a(999);
    n_checks++;
    if (bus_a.count_bcd !== 16'h0999) begin
      n_fail++;
      $display("FAIL carry_preload got %h required 0999", bus_a.count_bcd);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j <= 5; j++) begin
      if (j > 0) tick();
      exp_c = (j == 5) ? 16'h1000 : 16'h0999;
      exp_b = (j >= 1 && j <= 4);
      n_checks++;
      if (bus_a.count_bcd !== exp_c) begin
        n_fail++;
        $display("FAIL carry_count edge N+%0d got %h required %h", j, bus_a.count_bcd, exp_c);
      end
      n_checks++;
      if (bus_a.busy !== exp_b) begin
        n_fail++;
        $display("FAIL carry_busy edge N+%0d got %b required %b", j, bus_a.busy, exp_b);
      end
    end
  endtask

  task automatic test_borrow();
    logic [15:0] exp_c;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j <= 5; j++) begin
      if (j > 0) tick();
      exp_c = (j == 5) ? 16'h0999 : 16'h1000;
      n_checks++;
      if (bus_a.count_bcd !== exp_c) begin
        n_fail++;
        $display("FAIL borrow_count edge N+%0d got %h required %h", j, bus_a.count_bcd, exp_c);
      end
    end
  endtask

  task automatic test_reset_mid_ripple();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus_a.count_bcd, bus_a.busy, bus_a.empty} !== {16'h0000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL midripple_reset count=%h busy=%b empty=%b required 0000 0 1",
               bus_a.count_bcd, bus_a.busy, bus_a.empty);
    end
    tick();
    rst = 1'b0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    wait_idle();
    n_checks++;
    if (bus_a.count_bcd !== 16'h0001) begin
      n_fail++;
      $display("FAIL midripple_after got %h required 0001", bus_a.count_bcd);
    end
  endtask

  task automatic test_borrow_small();
    logic [15:0] exp_c;
    do_reset();
    preload_a(10);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j <= 3; j++) begin
      if (j > 0) tick();
      exp_c = (j == 3) ? 16'h0009 : 16'h0010;
      n_checks++;
      if (bus_a.count_bcd !== exp_c) begin
        n_fail++;
        $display("FAIL borrow10_count edge N+%0d got %h required %h", j, bus_a.count_bcd, exp_c);
      end
    end
  endtask

  task automatic test_full_empty();
    int r0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      wait_idle();
    end
    n_checks++;
    if (bus_b.count_bcd !== 16'h0003 || bus_b.full !== 1'b1) begin
      n_fail++;
      $display("FAIL full_reach count=%h full=%b required 0003 1", bus_b.count_bcd, bus_b.full);
    end
    r0 = rej_b;
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (bus_b.rejected !== 1'b0) begin
      n_fail++;
      $display("FAIL full_rej_early got %b required 0", bus_b.rejected);
    end
    tick();
    n_checks++;
    if (bus_b.rejected !== 1'b1 || bus_b.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_rej_pulse rejected=%b busy=%b required 1 0", bus_b.rejected, bus_b.busy);
    end
    tick();
    n_checks++;
    if (bus_b.rejected !== 1'b0 || bus_b.count_bcd !== 16'h0003 || (rej_b - r0) != 1) begin
      n_fail++;
      $display("FAIL full_rej_after rejected=%b count=%h pulses=%0d required 0 0003 1",
               bus_b.rejected, bus_b.count_bcd, rej_b - r0);
    end
    do_reset();
    r0 = rej_b;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    n_checks++;
    if (bus_b.count_bcd !== 16'h0000 || bus_b.empty !== 1'b1 || (rej_b - r0) != 1) begin
      n_fail++;
      $display("FAIL empty_rej count=%h empty=%b pulses=%0d required 0000 1 1",
               bus_b.count_bcd, bus_b.empty, rej_b - r0);
    end
  endtask

  task automatic test_simultaneous();
    int r0;
    int l0;
    do_reset();
    preload_a(5);
    r0 = rej_a;
    l0 = lost_a;
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    n_checks++;
    if (bus_a.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_busy got %b required 0", bus_a.busy);
    end
    tick();
    tick();
    tick();
    n_checks++;
    if (bus_a.count_bcd !== 16'h0005 || (rej_a - r0) != 0 || (lost_a - l0) != 0) begin
      n_fail++;
      $display("FAIL simul_result count=%h rej=%0d lost=%0d required 0005 0 0",
               bus_a.count_bcd, rej_a - r0, lost_a - l0);
    end
  endtask

  task automatic test_back_to_back();
    int l0;
    do_reset();
    preload_a(9);
    l0 = lost_a;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) tick();
    n_checks++;
    if (bus_a.count_bcd !== 16'h0011 || (lost_a - l0) != 0) begin
      n_fail++;
      $display("FAIL queued_two count=%h lost=%0d required 0011 0", bus_a.count_bcd, lost_a - l0);
    end
    l0 = lost_a;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (bus_a.lost !== 1'b1) begin
      n_fail++;
      $display("FAIL three_lost_pulse got %b required 1", bus_a.lost);
    end
    tick();
    n_checks++;
    if (bus_a.lost !== 1'b0) begin
      n_fail++;
      $display("FAIL three_lost_clear got %b required 0", bus_a.lost);
    end
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (bus_a.count_bcd !== 16'h0013 || (lost_a - l0) != 1) begin
      n_fail++;
      $display("FAIL three_result count=%h lost=%0d required 0013 1", bus_a.count_bcd, lost_a - l0);
    end
  endtask

  task automatic test_soak();
    int ma = 0;
    int mb = 0;
    int ra;
    int rb;
    int la;
    int lb;
    int exp_ra;
    int exp_rb;
    int r;
    logic e;
    logic x;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      r = $urandom_range(0, 19);
      e = (r <= 10) || (r == 19);
      x = (r >= 11);
      ra = rej_a;
      rb = rej_b;
      la = lost_a;
      lb = lost_b;
      exp_ra = 0;
      exp_rb = 0;
      if (e && !x) begin
        if (ma == 9999) exp_ra = 1; else ma++;
        if (mb == 3)    exp_rb = 1; else mb++;
      end else if (x && !e) begin
        if (ma == 0) exp_ra = 1; else ma--;
        if (mb == 0) exp_rb = 1; else mb--;
      end
      pulse(e, x, e, x);
      wait_idle();
      tick();
      n_checks++;
      if (bus_a.count_bcd !== to_bcd(ma) || !bcd_ok(bus_a.count_bcd, MAX_A)) begin
        n_fail++;
        $display("FAIL soak_a_count step %0d got %h required %h", i, bus_a.count_bcd, to_bcd(ma));
      end
      n_checks++;
      if (bus_b.count_bcd !== to_bcd(mb) || !bcd_ok(bus_b.count_bcd, MAX_B)) begin
        n_fail++;
        $display("FAIL soak_b_count step %0d got %h required %h", i, bus_b.count_bcd, to_bcd(mb));
      end
      n_checks++;
      if ((rej_a - ra) != exp_ra || (rej_b - rb) != exp_rb ||
          (lost_a - la) != 0 || (lost_b - lb) != 0) begin
        n_fail++;
        $display("FAIL soak_pulses step %0d rej=%0d/%0d lost=%0d/%0d required %0d/%0d 0/0",
                 i, rej_a - ra, rej_b - rb, lost_a - la, lost_b - lb, exp_ra, exp_rb);
      end
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    test_reset();
    rst = 1'b0;
    test_carry();
    test_borrow();
    test_reset_mid_ripple();
    test_borrow_small();
    test_full_empty();
    test_simultaneous();
    test_back_to_back();
    test_soak();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/occupancy_bcd_sequencer.md
# occupancy_bcd_sequencer

Sequencer that owns the lot's 4-digit BCD occupancy count and turns car-enter/car-exit event pulses into BCD increments and decrements. It rippling-carries one digit per clock, so no binary-to-BCD conversion is needed. It sits between the sensor-decoding FSM, which supplies the event pulses, and the seven-segment display driver, which consumes `count_bcd`. It arbitrates simultaneous events, refuses entries when the lot is full and exits when it is empty, and buffers one pending event per direction while an update is in flight.

## Interface
- `MAX_BCD`, default 16'h0500: lot capacity as 4-digit BCD. Every nibble must be 0–9, and the value must be nonzero and ≤ 16'h9999.
- `clk` input 1: sole clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `enter_req` input 1: one-cycle pulse, one car entered.
- `exit_req` input 1: one-cycle pulse, one car left.
- `count_bcd` output 16: committed occupancy. Digit 3 is in [15:12], digit 0 in [3:0].
- `full` output 1: `count_bcd == MAX_BCD` (combinational from the register).
- `empty` output 1: `count_bcd == 16'h0000`.
- `busy` output 1: FSM is not in IDLE.
- `rejected` output 1: one-cycle pulse when an event is refused because the lot is full or empty.
- `lost` output 1: one-cycle pulse when a request arrives while that direction's pending flag is already set.

## Operation
- **Registers:**
  - `pend_in`, `pend_out`: pending event flags.
  - `work[15:0]`: scratch copy of the count.
  - `idx[1:0]`: digit pointer.
  - `op`: INC or DEC.
  - `count_bcd`, and the FSM state.
- **Capture:** every cycle, `enter_req` sets `pend_in` and `exit_req` sets `pend_out`.
  - If a flag is already set and not being cleared this cycle, the new request is dropped and `lost` pulses.
  - Capture takes priority over a same-cycle clear: a request arriving in the clear cycle leaves the flag set.
- **IDLE**, evaluated on flag values registered before this edge:
  - Both flags set: clear both. Net change is zero; `count_bcd` is unchanged and there is no pulse.
  - Only `pend_in` set:
    - If `full`: clear it and pulse `rejected`.
    - Otherwise: clear it, set `work=count_bcd`, `op=INC`, `idx=0`, and go to STEP.
  - Only `pend_out` set:
    - If `empty`: clear it and pulse `rejected`.
    - Otherwise: clear it, set `work=count_bcd`, `op=DEC`, `idx=0`, and go to STEP.
- **STEP:** let `d = work[4*idx +: 4]`.
  - INC, `d==9`: write 0 to that digit, `idx++`, stay in STEP.
  - INC, otherwise: write `d+1`, commit `count_bcd = updated work`, go to IDLE.
  - DEC, `d==0`: write 9 to that digit, `idx++`, stay in STEP.
  - DEC, otherwise: write `d-1`, commit, go to IDLE.
- **Guards:** the full/empty guards guarantee that the ripple terminates by `idx==3`. STEP never advances `idx` past 3.
- **Commit:** `count_bcd` changes only at commit. Intermediate ripple values are never visible.
- **Invariant:** `count_bcd` is always valid BCD in the range 0..`MAX_BCD`.
- **Reset:** asynchronous `rst` forces IDLE and clears `pend_in`, `pend_out`, `work`, `idx`, `op`, and `count_bcd` to 0. `rejected` and `lost` go to 0. An in-flight update is abandoned, and the count reads 0 after reset.

## Timing
- Request sampled at edge N → flag set at edge N.
- IDLE acts at edge N+1, with `busy` high from N+1 when an update is accepted.
- Commit occurs at edge N+1+k, where k is the number of digits touched (1–4).
  - Example: 0041→0042 commits at N+2.
  - Example: 0999→1000 commits at N+5.
- Update cost: a bare update takes 1+k cycles of FSM occupancy (IDLE + k STEP edges). Back-to-back events are therefore accepted at up to one per 1+k cycles.
- `rejected` is high for the single cycle following the IDLE edge that refused the event.
- `lost` is high for the single cycle following the capture edge.
- `full` and `empty` follow `count_bcd` with zero additional latency.
- Reset deassertion is synchronised externally. The first event can be captured at the first edge after `rst` falls.

## Test plan
- Reset mid-ripple, `MAX_BCD`=16'h9999:
  - Preload to 0999 and pulse `enter_req`.
  - Assert `rst` two cycles later → `count_bcd`=0000 immediately, `busy`=0, `empty`=1.
  - Release `rst` and pulse `enter_req` → 0001.
- Carry ripple, `MAX_BCD`=16'h9999:
  - From 0999, pulse `enter_req` at edge N → `count_bcd`=1000 at N+5.
  - No other value is visible between N and N+5.
  - `busy` is high for 4 cycles.
- Borrow ripple: from 1000, pulse `exit_req` → 0999 after 4 STEP cycles.
  - From 0010, pulse `exit_req` → 0009.
- Full/empty refusal, `MAX_BCD`=16'h0003:
  - Send 4 spaced enters → count 0003, `full`=1, one `rejected` pulse, count stays 0003.
  - From 0000, an exit → one `rejected` pulse, count stays 0000.
- Simultaneous and queued events:
  - `enter_req` and `exit_req` in the same cycle at 0005 → count stays 0005, no pulse.
  - At 0009, two enters 1 cycle apart → second is held pending, final count 0011.
  - Three enters while busy → final count +2 and one `lost` pulse.
- Random soak: 10k random pulses → `count_bcd` always valid BCD and ≤ `MAX_BCD`.
  - Accepted INC/DEC totals match a reference model, counting `rejected` and `lost` events.
